// File: rtl/line_responder_pkg.sv
// Shared core-bus definitions: tag layout, opcode/target/source encodings,
// line geometry and the responder state encoding.
package line_responder_pkg;
  localparam int LINE_BEATS = 8;
  localparam int TAG_W      = 13;
  localparam int ID_W       = 7;
  localparam int OP_W       = 2;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_ATOMIC = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_CFG  = 2'd2,
    TGT_RSVD = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    SRC_CORE0 = 2'd0,
    SRC_CORE1 = 2'd1,
    SRC_DMA   = 2'd2,
    SRC_DBG   = 2'd3
  } source_e;

  typedef struct packed {
    op_e             op;
    target_e         target;
    source_e         source;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEMREQ = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/line_buffer.sv
// One-line staging buffer: synchronous write port, asynchronous read port.
// Contents are never reset; every entry is rewritten before it is read.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/line_responder.sv
// Line-read responder: accepts one core request, fetches the aligned 64-byte
// line from the backing store, then streams it back beat 0 first.
module line_responder #(
  parameter int LINE_BEATS = line_responder_pkg::LINE_BEATS,
  parameter int TAG_W      = line_responder_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reqcyc,
  input  logic [63:0]      req,
  input  logic [TAG_W-1:0] reqtag,
  output logic             reqack,
  output logic             respcyc,
  output logic [63:0]      resp,
  output logic [TAG_W-1:0] resptag,
  input  logic             respack,
  output logic             mem_req_valid,
  output logic [63:0]      mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rdata_valid,
  input  logic [63:0]      mem_rdata,
  output logic             err_bad_op
);
  import line_responder_pkg::*;

  localparam int               IDX_W    = $clog2(LINE_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BEATS - 1);
  localparam logic [63:0]      OFF_MASK = 64'(LINE_BEATS * 8 - 1);

  state_e           state, state_nxt;
  logic [63:0]      line_addr;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] fill_idx, resp_idx;
  logic [63:0]      buf_rdata;
  logic             accept, bad_op, fill_beat, resp_beat;

  // reqack is high in the cycle after acceptance; masking on it stops a
  // still-held reqcyc being taken twice when a bad op leaves us in IDLE.
  assign accept    = (state == IDLE) && reqcyc && !reqack;
  assign bad_op    = op_e'(reqtag[TAG_W-1 -: OP_W]) != OP_READ;
  assign fill_beat = (state == FILL) && mem_rdata_valid;
  assign resp_beat = (state == RESP) && respack;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !bad_op)                    state_nxt = MEMREQ;
      MEMREQ:  if (mem_req_ready)                        state_nxt = FILL;
      FILL:    if (fill_beat && fill_idx == LAST_IDX)    state_nxt = RESP;
      RESP:    if (resp_beat && resp_idx == LAST_IDX)    state_nxt = IDLE;
      default:                                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      reqack     <= 1'b0;
      err_bad_op <= 1'b0;
      line_addr  <= '0;
      tag_q      <= '0;
      fill_idx   <= '0;
      resp_idx   <= '0;
    end else begin
      reqack <= accept;
      if (accept) begin
        line_addr <= req & ~OFF_MASK;
        tag_q     <= reqtag;
      end
      if (accept && bad_op) err_bad_op <= 1'b1;
      // Indices wrap naturally, so each burst starts at entry 0.
      if (fill_beat) fill_idx <= fill_idx + 1'b1;
      if (resp_beat) resp_idx <= resp_idx + 1'b1;
    end

  line_buffer #(.DEPTH(LINE_BEATS), .WIDTH(64), .AW(IDX_W)) u_buf (
    .clk     (clk),
    .wr_en   (fill_beat),
    .wr_addr (fill_idx),
    .wr_data (mem_rdata),
    .rd_addr (resp_idx),
    .rd_data (buf_rdata)
  );

  assign mem_req_valid = (state == MEMREQ);
  assign mem_req_addr  = line_addr;
  assign respcyc       = (state == RESP);
  assign resp          = respcyc ? buf_rdata : '0;
  assign resptag       = tag_q;
endmodule

// File: tb/tb_line_responder.sv
// Scoreboard bench for line_responder: randomized core/memory traffic, a
// line-level reference model and a monitor that checks every presented beat.
module tb_line_responder;
  import line_responder_pkg::*;

  localparam int TW = line_responder_pkg::TAG_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reqcyc, reqack, respcyc, respack;
  logic [63:0]   req, resp, mem_req_addr, mem_rdata;
  logic [TW-1:0] reqtag, resptag;
  logic          mem_req_valid, mem_req_ready, mem_rdata_valid, err_bad_op;

  always #5 clk = ~clk;

  line_responder #(.LINE_BEATS(8), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
    .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata), .err_bad_op(err_bad_op)
  );

  typedef logic [7:0][63:0] line_t;
  typedef struct packed {
    logic [63:0]   addr;
    logic [TW-1:0] tag;
    logic          rd;
    line_t         line;
  } req_t;
  typedef struct packed {
    logic [63:0]   data;
    logic [TW-1:0] tag;
  } beat_t;

  req_t        pend_q[$];
  logic [63:0] addr_q[$];
  line_t       line_q[$];
  beat_t       beat_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_done = -100, burst_n = 0;
  bit active = 0, prev_ack = 0, prev_stall = 0;
  logic [63:0] prev_addr;
  int ack_mode = 1, rdy_mode = 1;
  bit beat_gaps = 0, err_exp = 0;
  bit m_busy = 0;
  int mbeat = 0, vcnt = 0;
  line_t cur_line;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void checkb(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pend_q.delete(); addr_q.delete(); line_q.delete(); beat_q.delete();
      active = 0; burst_n = 0; prev_ack = 0; prev_stall = 0; last_done = cyc - 10;
    end else begin
      if (reqack) begin
        checkb("reqack_single_cycle", prev_ack, 1'b0);
        checkb("reqack_only_when_idle", !active && (cyc - last_done >= 2), 1'b1);
        checkb("reqack_has_request", pend_q.size() != 0, 1'b1);
        if (pend_q.size() != 0) begin
          req_t r;
          r = pend_q.pop_front();
          if (r.rd) begin
            active = 1;
            addr_q.push_back(r.addr & ~64'h3f);
            line_q.push_back(r.line);
            for (int i = 0; i < 8; i++) beat_q.push_back('{data: r.line[i], tag: r.tag});
          end else begin
            last_done = cyc;
          end
        end
      end
      prev_ack = reqack;

      if (mem_req_valid) begin
        checkb("memreq_expected", addr_q.size() != 0, 1'b1);
        if (addr_q.size() != 0) begin
          check("mem_req_addr", mem_req_addr, addr_q[0]);
          if (mem_req_ready) void'(addr_q.pop_front());
        end
      end
      if (prev_stall) begin
        checkb("memreq_hold_valid", mem_req_valid, 1'b1);
        check("memreq_hold_addr", mem_req_addr, prev_addr);
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;

      if (last_done == cyc - 1) checkb("resp_idle_after_burst", respcyc, 1'b0);
      if (burst_n > 0 && ack_mode == 1) checkb("resp_consecutive", respcyc, 1'b1);

      if (respcyc) begin
        checkb("resp_expected", beat_q.size() != 0, 1'b1);
        if (beat_q.size() != 0) begin
          check("resp_data", resp, beat_q[0].data);
          check("resp_tag", 64'(resptag), 64'(beat_q[0].tag));
          if (respack) begin
            void'(beat_q.pop_front());
            burst_n++;
            if (burst_n == 8) begin
              burst_n = 0; active = 0; last_done = cyc;
            end
          end
        end
      end
    end
  end

  // Core-side acceptance of beats
  initial begin
    respack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       respack = 1'($urandom_range(0, 1));
        1:       respack = 1'b1;
        default: respack = ~respack;
      endcase
    end
  end

  // Backing-store model: one line per accepted request, stray beats when idle
  initial begin
    bit hs, took;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs   = mem_req_valid && mem_req_ready;
      took = mem_rdata_valid && m_busy;
      if (mem_req_valid && !mem_req_ready) vcnt++;
      @(posedge clk); #1;
      if (!reset_n) begin
        m_busy = 0; mbeat = 0; vcnt = 0;
      end else if (hs) begin
        vcnt = 0;
        checkb("mem_line_available", line_q.size() != 0, 1'b1);
        if (line_q.size() != 0) begin
          cur_line = line_q.pop_front(); m_busy = 1; mbeat = 0;
        end
      end else if (took) begin
        mbeat++;
        if (mbeat == 8) m_busy = 0;
      end
      if (m_busy && (!beat_gaps || $urandom_range(0, 2) != 0)) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = cur_line[mbeat];
      end else begin
        mem_rdata_valid = !m_busy && ($urandom_range(0, 5) == 0);
        mem_rdata       = {$urandom, $urandom};
      end
      case (rdy_mode)
        0:       mem_req_ready = 1'($urandom_range(0, 1));
        1:       mem_req_ready = 1'b1;
        default: mem_req_ready = (vcnt >= 5);
      endcase
    end
  end

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [1:0] op, input line_t line);
    req_t r;
    tag_t t;
    bit got;
    t.op = op_e'(op); t.target = target_e'($urandom_range(0, 3));
    t.source = source_e'($urandom_range(0, 3)); t.id = 7'($urandom);
    r.addr = a; r.tag = t; r.rd = (op == 2'(OP_READ)); r.line = line;
    pend_q.push_back(r);
    req = a; reqtag = t; reqcyc = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = reqack;
    end
    checkb("reqack_seen", got, 1'b1);
    @(posedge clk); #1;
    reqcyc = 1'b0; req = {$urandom, $urandom};
    if (!r.rd) begin
      err_exp = 1;
      @(negedge clk);
      checkb("err_bad_op_set", err_bad_op, 1'b1);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((beat_q.size() != 0 || pend_q.size() != 0 || active) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    checkb("drain_done", i < 1000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    line_t l;
    logic [63:0] a;
    int n, k;
    reset_n = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0;
    #3;
    checkb("rst_reqack", reqack, 1'b0);
    checkb("rst_respcyc", respcyc, 1'b0);
    checkb("rst_mem_req_valid", mem_req_valid, 1'b0);
    checkb("rst_err_bad_op", err_bad_op, 1'b0);
    check("rst_resp", resp, 64'h0);
    check("rst_resptag", 64'(resptag), 64'h0);
    check("rst_mem_req_addr", mem_req_addr, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic read, ready immediately, respack held high
    for (int i = 0; i < 8; i++) l[i] = 64'h10 + 64'(i);
    issue(64'h1234, 2'(OP_READ), l);
    drain();

    // respack toggling every cycle
    ack_mode = 2;
    issue(64'h5678_9abc, 2'(OP_READ), rand_line());
    drain();

    // mem_req_ready held low for five cycles
    ack_mode = 0; rdy_mode = 2;
    issue({$urandom, $urandom}, 2'(OP_READ), rand_line());
    drain();

    // second request raised while the first is still streaming
    ack_mode = 1; rdy_mode = 1;
    issue(64'h0000_0000_0000_0fc7, 2'(OP_READ), rand_line());
    for (int i = 0; i < 300 && !respcyc; i++) @(negedge clk);
    checkb("resp_started", respcyc, 1'b1);
    issue(64'h0000_0000_0001_0040, 2'(OP_READ), rand_line());
    drain();

    // non-READ request: ack, sticky error, no memory traffic or beats
    issue(64'h2000, 2'(OP_WRITE), rand_line());
    repeat (5) @(negedge clk);
    checkb("err_bad_op_sticky", err_bad_op, 1'b1);

    // randomized mix
    ack_mode = 0; rdy_mode = 0; beat_gaps = 1;
    repeat (40) begin
      a = {$urandom, $urandom};
      issue(a, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'(OP_READ),
            rand_line());
    end
    drain();
    checkb("err_bad_op_after_mix", err_bad_op, err_exp);

    // reset in the middle of a fill
    rdy_mode = 1; beat_gaps = 0;
    issue(64'hdead_beef_0000_1238, 2'(OP_READ), rand_line());
    for (int i = 0; i < 200 && !(m_busy && mbeat >= 4); i++) @(negedge clk);
    checkb("fill_reached_beat4", m_busy && mbeat >= 4, 1'b1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkb("arst_reqack", reqack, 1'b0);
    checkb("arst_respcyc", respcyc, 1'b0);
    checkb("arst_mem_req_valid", mem_req_valid, 1'b0);
    checkb("arst_err_bad_op", err_bad_op, 1'b0);
    check("arst_resp", resp, 64'h0);
    check("arst_resptag", 64'(resptag), 64'h0);
    check("arst_mem_req_addr", mem_req_addr, 64'h0);
    err_exp = 0;
    repeat (2) @(negedge clk); #2;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (respcyc) n++;
    end
    check("no_resp_after_reset", 64'(n), 64'h0);

    // traffic resumes cleanly after reset
    ack_mode = 0; rdy_mode = 0; beat_gaps = 1;
    k = 0;
    repeat (10) begin
      issue({$urandom, $urandom}, 2'(OP_READ), rand_line());
      k++;
    end
    drain();
    checkb("err_bad_op_post_reset", err_bad_op, err_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_responder.md
LINE_RESPONDER -- requirements
Module: line_responder

Interface
REQ-001 The block SHALL expose these parameters, one per line: LINE_BEATS, 8, 64-bit beats per 64-byte line; TAG_W, 13, width of request/response tag.
REQ-002 The block SHALL expose these ports, one per line:
 clk  input  1  single clock; all state updates on its rising edge
 reset_n  input  1  asynchronous, active-low reset
 reqcyc  input  1  core request valid; held by core until reqack
 req  input  64  request byte address
 reqtag  input  TAG_W  {op, target, source, 7-bit id}
 reqack  output  1  one-cycle request acceptance pulse
 respcyc  output  1  response beat valid
 resp  output  64  response beat data
 resptag  output  TAG_W  tag of the request being answered
 respack  input  1  core accepts current beat
 mem_req_valid  output  1  backing-store line read request
 mem_req_addr  output  64  64-byte-aligned line address
 mem_req_ready  input  1  backing store accepts request
 mem_rdata_valid  input  1  backing-store fill beat valid
 mem_rdata  input  64  backing-store fill beat data
 err_bad_op  output  1  sticky: non-READ request received

Function
REQ-003 The state machine SHALL have states IDLE, MEMREQ, FILL, RESP.
REQ-004 In IDLE with reqcyc=1, the block SHALL latch req & ~63 and reqtag, drive reqack=1 on the next cycle only, and move to MEMREQ.
REQ-005 reqack SHALL never be asserted outside the IDLE-to-MEMREQ transition; requests arriving while busy stay pending, unacknowledged.
REQ-006 A request whose op field is not READ SHALL be acknowledged, SHALL set err_bad_op, and SHALL return to IDLE with no response beats.
REQ-007 In MEMREQ, mem_req_valid SHALL be 1 with mem_req_addr = latched line address until a cycle with mem_req_ready=1, then move to FILL.
REQ-008 In FILL, each mem_rdata_valid beat SHALL be written to line buffer entry fill_idx (3-bit); fill_idx SHALL increment and wrap 7->0; the cycle after the 8th beat the state SHALL be RESP.
REQ-009 In RESP, respcyc SHALL be 1, resp SHALL equal buffer[resp_idx], resptag SHALL equal the latched tag; resp_idx SHALL advance only on respcyc && respack.
REQ-010 Beats SHALL be returned in ascending address order, beat 0 = bytes 0-7 of the aligned line, regardless of req[5:0].
REQ-011 When beat 7 is accepted the state SHALL return to IDLE and respcyc SHALL be 0 for at least one cycle before any further burst.
REQ-012 With respack held high, the 8 beats SHALL appear on 8 consecutive cycles.
REQ-013 mem_rdata_valid outside FILL SHALL be ignored.
REQ-014 reqcyc=1 in the final RESP cycle SHALL NOT be acknowledged until the following IDLE cycle.

Reset
REQ-015 On reset_n=0, immediately and regardless of clk: state=IDLE; reqack, respcyc, mem_req_valid, err_bad_op=0; fill_idx, resp_idx=0; resp, resptag, mem_req_addr=0.
REQ-016 Reset asserted mid-burst SHALL abandon the burst; no beat SHALL be emitted after reset_n rises until a new request is acked.
REQ-017 Line buffer contents SHALL NOT require reset.

Structure
REQ-018 The op/target/source tag encodings, TAG_W, LINE_BEATS, and the state enum SHALL reside in the shared core-bus package.
REQ-019 The 8x64 line buffer SHALL be a sub-module named line_buffer, with a write port and a read port.

Verification
REQ-020 Request req=0x1234 as READ, mem_req_ready immediate, fill beats 0x10..0x17, respack=1 -> reqack one cycle, mem_req_addr=0x1200, respcyc 8 consecutive cycles with resp 0x10..0x17, then respcyc=0.
REQ-021 Same, respack low every other cycle -> each beat held stable while respack=0; order unchanged; 8 beats total.
REQ-022 Second reqcyc asserted during RESP -> no reqack until after beat 7 accepted and one idle cycle elapses.
REQ-023 WRITE-op request -> reqack pulse, err_bad_op=1 and stays 1, no mem_req_valid, no respcyc.
REQ-024 reset_n pulsed low after fill beat 3 -> all outputs 0 asynchronously; after release, no respcyc until new request.
REQ-025 mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles.
